// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
// Optional build macro: COUNTER_SEQ_AUTOSTOP_EN (see counter_sequencer.sv).
package counter_seq_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Direction encoding of SW[9].
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // KEY indices for the three operator functions.
    localparam int K_TOGGLE = 1;
    localparam int K_STEP   = 2;
    localparam int K_LOAD   = 3;

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus falling-edge detector for one active-low
// pushbutton. Every register resets to the released (high) level, so
// reset itself never produces a press pulse.
module key_edge (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic key_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the button and keep one cycle of history for edge detection.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of its neighbour; blocking here would collapse the chain.
        if (!Resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= key_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // High for exactly one cycle after the synchronized level falls.
    assign pulse_o = prev_q & ~sync_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/step/load controller around an N-bit up/down counter.
// LEDR[7:0] = count, LEDR[8] = running, LEDR[9] = sticky wrap flag.
// Define COUNTER_SEQ_AUTOSTOP_EN to suppress wrapping: the count parks at
// its terminal value, the wrap flag sets and the sequencer returns to idle.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int N        = 8,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [3:1] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [3:1]    key_pulse;
    logic [9:0]    sw_meta_q;
    logic [9:0]    sw_q;

    state_t        state_q;
    logic [N-1:0]  count_q;
    logic [N-1:0]  count_d;
    logic          wrap_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    logic          load_p;
    logic          toggle_p;
    logic          step_p;
    logic          dir;
    logic          fast;
    logic          tick;
    logic          at_term;
    logic          do_update;

    for (genvar gi = 1; gi <= 3; gi++) begin : g_key
        key_edge u_key (
            .CLOCK_50 (CLOCK_50),
            .Resetn   (Resetn),
            .key_i    (KEY[gi]),
            .pulse_o  (key_pulse[gi])
        );
    end

    assign load_p   = key_pulse[K_LOAD];
    assign toggle_p = key_pulse[K_TOGGLE];
    assign step_p   = key_pulse[K_STEP];

    // Two-flop synchronizer for the switches, reset to the released level.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sw_meta_q <= '1;
            sw_q      <= '1;
        end else begin
            sw_meta_q <= SW;
            sw_q      <= sw_meta_q;
        end
    end

    // Tick generation, next count value and terminal-value detection.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a
        // value unassigned and infer a latch.
        dir       = sw_q[9];
        fast      = sw_q[8];
        tick      = fast || (presc_q == PRESC_MAX);
        presc_d   = (fast || presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        at_term   = (dir == DIR_UP) ? (count_q == '1) : (count_q == '0);
        count_d   = (dir == DIR_UP) ? count_q + N'(1) : count_q - N'(1);
        do_update = (state_q == S_IDLE) ? step_p : tick;
    end

    // Sequencer FSM: load beats toggle beats step/tick in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
        end else if (load_p) begin
            state_q <= S_IDLE;
            count_q <= sw_q[N-1:0];
            wrap_q  <= 1'b0;
        end else if (toggle_p) begin
            if (state_q == S_IDLE) begin
                state_q <= S_RUN;
                presc_q <= '0;
            end else begin
                state_q <= S_IDLE;
            end
        end else begin
            if (state_q == S_RUN) begin
                presc_q <= presc_d;
            end
            if (do_update) begin
`ifdef COUNTER_SEQ_AUTOSTOP_EN
                if (at_term) begin
                    wrap_q  <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    count_q <= count_d;
                end
`else
                count_q <= count_d;
                if (at_term) begin
                    wrap_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign LEDR = {wrap_q, (state_q == S_RUN), count_q};

endmodule
